// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: executes multiplexed address/data bus cycles on a V3023-style RTC,
// preceded by a two-write initialisation sequence after reset.
module rtc_bus_ctrl #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int T_INIT  = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Acceso,
  input  logic       Mod,
  input  logic [7:0] Dir,
  input  logic [7:0] Dato_wr,
  output logic [7:0] Dato_rd,
  output logic       FRW,
  output logic       CS_n,
  output logic       A_D,
  output logic       RD_n,
  output logic       WR_n,
  inout  wire  [7:0] AD
);
  localparam int M1 = T_SETUP > T_PULSE ? T_SETUP : T_PULSE;
  localparam int M2 = T_HOLD > T_INIT ? T_HOLD : T_INIT;
  localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
  typedef enum logic [3:0] {
    INIT_WAIT, IDLE, ADDR_SETUP, ADDR_PULSE, ADDR_HOLD,
    DATA_SETUP, DATA_PULSE, DATA_HOLD, DONE
  } state_t;
  state_t st, ns;
  logic [CW-1:0] cnt, ncnt, lim;
  logic [7:0] dir, dat, n_dir, n_dat, ad_q;
  logic wr, n_wr, pend, n_pend, acc_q, ad_oe, addr_ph, data_ph;
  assign AD = ad_oe ? ad_q : 8'hzz;
  always_comb begin
    lim = (st == INIT_WAIT) ? CW'(T_INIT - 1) :
          (st == ADDR_SETUP || st == DATA_SETUP) ? CW'(T_SETUP - 1) :
          (st == ADDR_PULSE || st == DATA_PULSE) ? CW'(T_PULSE - 1) : CW'(T_HOLD - 1);
    ns = st;
    ncnt = (cnt == lim) ? '0 : cnt + 1'b1;
    n_dir = dir;
    n_dat = dat;
    n_wr = wr;
    n_pend = pend;
    case (st)
      INIT_WAIT: if (cnt == lim) begin
        ns = ADDR_SETUP;
        n_dir = 8'h02;
        n_dat = 8'h10;
        n_wr = 1'b1;
        n_pend = 1'b1;
      end
      IDLE: begin
        ncnt = '0;
        if (Acceso && !acc_q) begin
          ns = ADDR_SETUP;
          n_dir = Dir;
          n_dat = Dato_wr;
          n_wr = Mod || (Dir == 8'hF0);
        end
      end
      ADDR_SETUP: if (cnt == lim) ns = ADDR_PULSE;
      ADDR_PULSE: if (cnt == lim) ns = ADDR_HOLD;
      ADDR_HOLD:  if (cnt == lim) ns = DATA_SETUP;
      DATA_SETUP: if (cnt == lim) ns = DATA_PULSE;
      DATA_PULSE: if (cnt == lim) ns = DATA_HOLD;
      DATA_HOLD:  if (cnt == lim) ns = DONE;
      DONE: begin
        // second init write follows the first directly, without passing IDLE
        ncnt = '0;
        ns = pend ? ADDR_SETUP : IDLE;
        n_dat = pend ? 8'h00 : dat;
        n_pend = 1'b0;
      end
      default: ns = IDLE;
    endcase
    addr_ph = ns inside {ADDR_SETUP, ADDR_PULSE, ADDR_HOLD};
    data_ph = ns inside {DATA_SETUP, DATA_PULSE, DATA_HOLD};
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st <= INIT_WAIT;
      cnt <= '0;
      dir <= '0;
      dat <= '0;
      wr <= 1'b0;
      pend <= 1'b0;
      acc_q <= 1'b0;
      ad_q <= '0;
      ad_oe <= 1'b0;
      CS_n <= 1'b1;
      A_D <= 1'b1;
      RD_n <= 1'b1;
      WR_n <= 1'b1;
      FRW <= 1'b0;
      Dato_rd <= '0;
    end else begin
      st <= ns;
      cnt <= ncnt;
      dir <= n_dir;
      dat <= n_dat;
      wr <= n_wr;
      pend <= n_pend;
      acc_q <= Acceso;
      ad_q <= addr_ph ? n_dir : n_dat;
      ad_oe <= addr_ph || (data_ph && n_wr);
      CS_n <= !(addr_ph || data_ph);
      A_D <= !addr_ph;
      WR_n <= !(ns == ADDR_PULSE || (ns == DATA_PULSE && n_wr));
      RD_n <= !(ns == DATA_PULSE && !n_wr);
      FRW <= ns == DONE;
      if (st == DATA_PULSE && cnt == lim && !wr) Dato_rd <= AD;
    end
  end
endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: directed stimulus with an expected-transaction queue checked at each FRW pulse.
module tb_rtc_bus_ctrl;
  logic CLK = 0, RST = 1, Acceso = 0, Mod = 0;
  logic [7:0] Dir = 0, Dato_wr = 0, rd_val = 8'h37, rd_model = 0;
  logic [7:0] Dato_rd;
  logic FRW, CS_n, A_D, RD_n, WR_n;
  wire [7:0] AD;
  int tests = 0, fails = 0, cyc = 0, fc = 0, r = 0;
  int na = 0, nd = 0, nr = 0, berr = 0;
  logic [7:0] ma = 0, md = 0;
  typedef struct {logic w; logic [7:0] a, d, rd; int fc;} exp_t;
  exp_t q[$];

  rtc_bus_ctrl dut (.CLK(CLK), .RST(RST), .Acceso(Acceso), .Mod(Mod), .Dir(Dir),
    .Dato_wr(Dato_wr), .Dato_rd(Dato_rd), .FRW(FRW), .CS_n(CS_n), .A_D(A_D),
    .RD_n(RD_n), .WR_n(WR_n), .AD(AD));

  // RTC model drives the bus only while the read strobe is low; pullups expose a released bus as FF
  assign AD = !RD_n ? rd_val : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (AD[i]);
  end

  always #5 CLK = ~CLK;
  initial forever @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic req(input logic m, input logic [7:0] a, input logic [7:0] d, input int hold,
                     output int f);
    logic w;
    @(negedge CLK);
    Mod = m; Dir = a; Dato_wr = d; Acceso = 1;
    w = m || (a == 8'hF0);
    if (!w) rd_model = rd_val;
    f = cyc + 17;
    q.push_back('{w, a, d, rd_model, f});
    repeat (hold) @(negedge CLK);
    Acceso = 0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_timeout"}, q.size(), 0);
    q.delete();
  endtask

  task automatic push_init();
    r = cyc;
    q.push_back('{1'b1, 8'h02, 8'h10, 8'h00, r + 32});
    q.push_back('{1'b1, 8'h02, 8'h00, 8'h00, r + 49});
  endtask

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        na = 0; nd = 0; nr = 0; berr = 0;
      end else begin
        if (!CS_n && !A_D && !WR_n) begin na++; ma = AD; end
        if (!CS_n && A_D && !WR_n) begin nd++; md = AD; end
        if (!RD_n) begin nr++; if (AD !== rd_val) berr++; end
        if (!RD_n && !WR_n) berr++;
        if (RD_n && WR_n && (CS_n || (A_D && q.size() > 0 && !q[0].w)) && AD !== 8'hFF) berr++;
        if (FRW) begin
          chk("frw_expected", q.size() > 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("addr_pulses", na, 4);
            chk("addr_value", ma, e.a);
            chk("wr_data_pulses", nd, e.w ? 4 : 0);
            chk("rd_pulses", nr, e.w ? 0 : 4);
            if (e.w) chk("wr_data_value", md, e.d);
            chk("dato_rd", Dato_rd, e.rd);
            chk("frw_cycle", cyc, e.fc);
            chk("bus_errors", berr, 0);
          end
          na = 0; nd = 0; nr = 0; berr = 0;
        end
      end
    end
  end

  initial begin
    #1 RST = 0;
    @(negedge CLK);
    chk("rst_cs_n", CS_n, 1);
    chk("rst_a_d", A_D, 1);
    chk("rst_rd_n", RD_n, 1);
    chk("rst_wr_n", WR_n, 1);
    chk("rst_frw", FRW, 0);
    chk("rst_dato_rd", Dato_rd, 0);
    chk("rst_ad_released", AD, 8'hFF);
    repeat (2) @(negedge CLK);
    RST = 1;
    push_init();
    repeat (10) @(negedge CLK);
    chk("init_wait_cs_n", CS_n, 1);
    wait_done("init");
    chk("idle_cs_n", CS_n, 1);

    req(1, 8'h21, 8'h45, 1, fc);
    wait_done("write");

    Dato_wr = 8'h5A;
    req(0, 8'h41, 8'h5A, 1, fc);
    wait_done("read");

    req(1, 8'h33, 8'h99, 8, fc);
    repeat (2) @(negedge CLK);
    Acceso = 1;
    repeat (2) @(negedge CLK);
    Acceso = 0;
    wait_done("held");
    repeat (25) @(negedge CLK);
    rd_val = 8'h6C;
    req(0, 8'h12, 8'h5A, 1, fc);
    wait_done("second");

    req(0, 8'hF0, 8'h00, 1, fc);
    wait_done("xfer_cmd");

    req(1, 8'h55, 8'hAA, 1, fc);
    while (cyc < fc - 5) @(negedge CLK);
    chk("pre_rst_wr_n", WR_n, 0);
    #2 RST = 0;
    #1;
    chk("abort_wr_n", WR_n, 1);
    chk("abort_cs_n", CS_n, 1);
    chk("abort_rd_n", RD_n, 1);
    chk("abort_a_d", A_D, 1);
    chk("abort_frw", FRW, 0);
    chk("abort_ad_released", AD, 8'hFF);
    chk("abort_dato_rd", Dato_rd, 0);
    q.delete();
    rd_model = 0;
    repeat (3) @(negedge CLK);
    RST = 1;
    push_init();
    wait_done("reinit");
    repeat (5) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rtc_bus_ctrl.md
Name: rtc_bus_ctrl

Overview:
- Responder side of the menu FSM's RTC access handshake.
- Accepts an access request (Acceso, Mod, Dir, write data) and executes one multiplexed address/data bus cycle on the V3023-style RTC: CS_n, A_D, RD_n, WR_n, bidirectional AD.
- Returns a one-cycle FRW pulse when the cycle completes. On reset it first runs the two-write RTC initialisation sequence, also closed by FRW pulses.
- Sits between the menu/pointer FSMs and the RTC pins.

Parameters:
T_SETUP, 2, cycles of setup before each strobe (address and data phase)
T_PULSE, 4, cycles each RD_n/WR_n strobe is held low
T_HOLD, 2, cycles of hold after each strobe
T_INIT, 16, power-up wait cycles before the init sequence starts

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous, active-low reset
Acceso  in  1  access request level; rising edge starts a transaction
Mod  in  1  1 = write cycle, 0 = read cycle
Dir  in  8  RTC register address
Dato_wr  in  8  data written in write cycles
Dato_rd  out  8  last byte read from RTC
FRW  out  1  one-cycle pulse: transaction (or init write) finished
CS_n  out  1  RTC chip select, active low
A_D  out  1  0 = address phase, 1 = data phase
RD_n  out  1  read strobe, active low
WR_n  out  1  write strobe, active low
AD  inout  8  multiplexed address/data bus, tri-stated when not driven

Behaviour:
- Reset (RST=0, async): CS_n=1, A_D=1, RD_n=1, WR_n=1, AD=Z, FRW=0, Dato_rd=8'h00. State goes to INIT_WAIT, init counter cleared, Acceso edge register cleared.
- Reset asserted mid-transaction aborts immediately: strobes go high, AD releases, and the init sequence restarts after release.
- State list: INIT_WAIT, IDLE, ADDR_SETUP, ADDR_PULSE, ADDR_HOLD, DATA_SETUP, DATA_PULSE, DATA_HOLD, DONE.
- Phase counter width: ceil(log2(max parameter+1)). Each SETUP/PULSE/HOLD state lasts exactly its parameter in cycles.
- INIT_WAIT:
  - Waits T_INIT cycles.
  - Then issues write {addr 8'h02, data 8'h10}, FRW pulse, then write {8'h02, 8'h00}, FRW pulse, then goes to IDLE.
  - Acceso is ignored during init.
- Request acceptance:
  - In IDLE, Acceso=1 with the previous-cycle Acceso=0 (registered edge) latches Dir, Mod and Dato_wr. Next cycle enters ADDR_SETUP.
  - Acceso held high for many cycles produces exactly one transaction.
  - Rising edges while not IDLE are ignored, not queued.
- Dir=8'hF0 (transfer command) is always a write cycle regardless of Mod.
- Address phase: CS_n=0, A_D=0, AD driven with latched Dir.
  - ADDR_SETUP: WR_n=1.
  - ADDR_PULSE: WR_n=0.
  - ADDR_HOLD: WR_n=1, AD still driven.
- Data phase: CS_n=0, A_D=1.
  - Write cycle: AD driven with latched data; WR_n=0 during DATA_PULSE only.
  - Read cycle: AD released from DATA_SETUP onward; RD_n=0 during DATA_PULSE only. Dato_rd is loaded from AD on the clock edge that ends the last DATA_PULSE cycle.
  - Dato_rd is unchanged by writes.
- DONE: CS_n=1, A_D=1, strobes high, AD=Z, FRW=1 for exactly this cycle. Next state is IDLE (or the next init write during init).
- RD_n and WR_n are never low simultaneously. AD is never driven while RD_n=0.
- Latency: edge sampled at cycle N, FRW high at cycle N+1+2*(T_SETUP+T_PULSE+T_HOLD). With default parameters this is N+17.
- A new edge is accepted on the first IDLE cycle after DONE at the earliest.

Test Plan:
1. Apply reset, release, hold Acceso=0 -> outputs at reset values; after 16 cycles two write cycles to AD=8'h02 with data 8'h10 then 8'h00; one FRW pulse after each; then IDLE.
2. After init: Mod=1, Dir=8'h21, Dato_wr=8'h45, Acceso rise at cycle N -> WR_n low 4 cycles with AD=8'h21, A_D=0; then WR_n low 4 cycles with AD=8'h45, A_D=1; FRW=1 at N+17 only.
3. Mod=0, Dir=8'h41, bus model drives 8'h37 while RD_n=0 -> AD tri-stated in data phase, Dato_rd=8'h37 after DATA_PULSE, FRW at N+17, WR_n stays 1 in data phase.
4. Acceso held high 8 cycles, then low, then high again after FRW -> exactly two transactions; an edge presented mid-transaction produces no extra cycle.
5. Dir=8'hF0, Mod=0, Dato_wr=8'h00 -> write cycle (WR_n strobes, RD_n never low), FRW pulse, Dato_rd unchanged.
6. RST low during DATA_PULSE of a write -> same-cycle WR_n=1, CS_n=1, AD=Z, no FRW; after release the full init sequence repeats.
